sdram_frame_arbiter: RTL and testbench

Access scheduler sitting between the CMOS capture write FIFO, the VGA scan-out read FIFO and the SDRAM command engine inside `vga_module`. Decides each cycle-group whether the SDRAM performs an auto-refresh, a read burst or a write burst. Owns the frame-buffer address pointers and the double-buffer selection. Issues one command at a time over a valid/ready handshake and waits for completion.

---
 rtl/sdram_frame_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sdram_frame_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_arbiter.sv
// SDRAM access scheduler for the VGA frame buffer: arbitrates refresh, scan-out reads
// and camera writes, and owns the double-buffer address pointers.
module sdram_frame_arbiter #(
    parameter int unsigned ADDR_W         = 24,
    parameter int unsigned BURST          = 256,
    parameter int unsigned FRAME_WORDS    = 307200,
    parameter int unsigned REFRESH_CYCLES = 390,
    parameter int unsigned RD_LOW         = 256
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              init_done,
    input  logic [9:0]        wr_fifo_level,
    input  logic [9:0]        rd_fifo_level,
    input  logic              cmos_vsyn_pulse,
    input  logic              vga_vsyn_pulse,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [8:0]        cmd_len,
    input  logic              cmd_done,
    output logic              wr_buf,
    output logic              rd_buf,
    output logic              refresh_ovf
);

    localparam int unsigned   PW       = ADDR_W - 1;
    localparam int unsigned   TW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [PW-1:0] BURST_P  = PW'(BURST);
    localparam logic [PW-1:0] FRAME_P  = PW'(FRAME_WORDS);
    localparam logic [TW-1:0] TMR_LAST = TW'(REFRESH_CYCLES - 1);
    localparam logic [8:0]    LEN_P    = 9'(BURST);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_e;
    typedef enum logic [1:0] {CMD_WR = 2'b00, CMD_RD = 2'b01, CMD_REF = 2'b10} cmd_e;

    state_e            state_q, state_d;
    cmd_e              type_q, type_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        len_q, len_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, last_buf_q, last_buf_d;
    logic              cmos_lat_q, cmos_lat_d, vga_lat_q, vga_lat_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [1:0]        ref_pend_q, ref_pend_d;
    logic              ovf_q, ovf_d;

    logic wrap, ref_hs, wr_out, rd_out, wr_done, rd_done, cmos_apply, vga_apply, rd_req, wr_req;

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_buf_d   = wr_buf_q;
        rd_buf_d   = rd_buf_q;
        last_buf_d = last_buf_q;
        cmos_lat_d = cmos_lat_q;
        vga_lat_d  = vga_lat_q;
        ovf_d      = ovf_q;
        ref_pend_d = ref_pend_q;

        wrap   = (tmr_q == TMR_LAST);
        tmr_d  = wrap ? '0 : tmr_q + 1'b1;
        ref_hs = (state_q == S_ISSUE) && valid_q && cmd_ready && (type_q == CMD_REF);
        if (wrap && !ref_hs) begin
            if (ref_pend_q != 2'd3) ref_pend_d = ref_pend_q + 2'd1;
        end else if (!wrap && ref_hs) begin
            ref_pend_d = ref_pend_q - 2'd1;
        end
        if (wrap && (ref_pend_q == 2'd3)) ovf_d = 1'b1;

        // A vsync arriving while the matching burst is outstanding waits for its
        // completion; that completion then resets the pointer instead of advancing it.
        wr_out     = (state_q != S_IDLE) && (type_q == CMD_WR);
        rd_out     = (state_q != S_IDLE) && (type_q == CMD_RD);
        wr_done    = (state_q == S_BUSY) && cmd_done && (type_q == CMD_WR);
        rd_done    = (state_q == S_BUSY) && cmd_done && (type_q == CMD_RD);
        cmos_apply = wr_out ? (wr_done && (cmos_lat_q || cmos_vsyn_pulse)) : cmos_vsyn_pulse;
        vga_apply  = rd_out ? (rd_done && (vga_lat_q || vga_vsyn_pulse)) : vga_vsyn_pulse;
        cmos_lat_d = (wr_out && !wr_done) ? (cmos_lat_q | cmos_vsyn_pulse) : 1'b0;
        vga_lat_d  = (rd_out && !rd_done) ? (vga_lat_q | vga_vsyn_pulse) : 1'b0;

        if (cmos_apply) begin
            last_buf_d = wr_buf_q;
            wr_buf_d   = ~wr_buf_q;
            wr_ptr_d   = '0;
        end else if (wr_done) begin
            wr_ptr_d = (wr_ptr_q + BURST_P >= FRAME_P) ? '0 : wr_ptr_q + BURST_P;
        end
        if (vga_apply) begin
            rd_buf_d = last_buf_d;
            rd_ptr_d = '0;
        end else if (rd_done) begin
            rd_ptr_d = (rd_ptr_q + BURST_P >= FRAME_P) ? '0 : rd_ptr_q + BURST_P;
        end

        rd_req = 32'(rd_fifo_level) < RD_LOW;
        wr_req = 32'(wr_fifo_level) >= BURST;

        unique case (state_q)
            S_IDLE: begin
                // Addresses come from the post-vsync values so a same-cycle vsync is honoured.
                if (init_done && ((ref_pend_q != 2'd0) || rd_req || wr_req)) begin
                    state_d = S_ISSUE;
                    if (ref_pend_q != 2'd0) begin
                        type_d = CMD_REF;
                        addr_d = '0;
                        len_d  = '0;
                    end else if (rd_req) begin
                        type_d = CMD_RD;
                        addr_d = {rd_buf_d, rd_ptr_d};
                        len_d  = LEN_P;
                    end else begin
                        type_d = CMD_WR;
                        addr_d = {wr_buf_d, wr_ptr_d};
                        len_d  = LEN_P;
                    end
                end
            end
            S_ISSUE: begin
                if (valid_q && cmd_ready) begin
                    state_d = S_BUSY;
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_BUSY: begin
                if (cmd_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_IDLE;
            type_q     <= CMD_WR;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_buf_q   <= 1'b0;
            rd_buf_q   <= 1'b1;
            last_buf_q <= 1'b1;
            cmos_lat_q <= 1'b0;
            vga_lat_q  <= 1'b0;
            tmr_q      <= '0;
            ref_pend_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_buf_q   <= wr_buf_d;
            rd_buf_q   <= rd_buf_d;
            last_buf_q <= last_buf_d;
            cmos_lat_q <= cmos_lat_d;
            vga_lat_q  <= vga_lat_d;
            tmr_q      <= tmr_d;
            ref_pend_q <= ref_pend_d;
            ovf_q      <= ovf_d;
        end
    end

    assign cmd_valid   = valid_q;
    assign cmd_type    = type_q;
    assign cmd_addr    = addr_q;
    assign cmd_len     = len_q;
    assign wr_buf      = wr_buf_q;
    assign rd_buf      = rd_buf_q;
    assign refresh_ovf = ovf_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Scoreboard bench for sdram_frame_arbiter: expected commands are queued by the stimulus
// thread and popped by an engine/monitor process at every accepted command.
module tb_sdram_frame_arbiter;

    localparam int unsigned ENG_LAT = 10;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        init_done = 1'b0;
    logic [9:0]  wr_fifo_level = '0;
    logic [9:0]  rd_fifo_level = 10'd1023;
    logic        cmos_vsyn_pulse = 1'b0;
    logic        vga_vsyn_pulse = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [1:0]  cmd_type;
    logic [23:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        cmd_done = 1'b0;
    logic        wr_buf, rd_buf, refresh_ovf;

    sdram_frame_arbiter #(
        .ADDR_W(24), .BURST(256), .FRAME_WORDS(307200), .REFRESH_CYCLES(390), .RD_LOW(256)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .init_done(init_done),
        .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
        .cmos_vsyn_pulse(cmos_vsyn_pulse), .vga_vsyn_pulse(vga_vsyn_pulse),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done),
        .wr_buf(wr_buf), .rd_buf(rd_buf), .refresh_ovf(refresh_ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  typ;
        logic [23:0] addr;
        logic [8:0]  len;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t mon_act, mon_exp;
    int   total = 0, bad = 0;
    int   wr_hs = 0, rd_hs = 0, bg_ref = 0, busy_cnt = 0, cyc = 0, errs = 0, guard = 0;
    bit   stall = 1'b0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] t, input logic [23:0] a, input logic [8:0] l);
        exp_q.push_back(cmd_t'{typ: t, addr: a, len: l});
    endtask

    task automatic at_pos(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        if (!RSTn) cyc = 0;
        else cyc++;
    end

    // Engine model and monitor: accepts commands, returns cmd_done ENG_LAT cycles later.
    initial forever begin
        @(negedge CLK);
        cmd_done = 1'b0;
        cmd_ready = !stall;
        if (!RSTn) begin
            busy_cnt = 0;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) cmd_done = 1'b1;
            end
            if (cmd_valid && cmd_ready) begin
                busy_cnt = ENG_LAT;
                mon_act = {cmd_type, cmd_addr, cmd_len};
                if (cmd_type == 2'b10 && (exp_q.size() == 0 || exp_q[0].typ != 2'b10)) begin
                    bg_ref++;
                    chk("bg_refresh_fields", {cmd_addr, cmd_len}, 48'd0);
                end else if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cmd actual=%0h required=none", mon_act);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("cmd", mon_act, mon_exp);
                end
                if (cmd_type == 2'b00) wr_hs++;
                if (cmd_type == 2'b01) rd_hs++;
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_type", cmd_type, 0);
        chk("rst_addr", cmd_addr, 0);
        chk("rst_len", cmd_len, 0);
        chk("rst_wr_buf", wr_buf, 0);
        chk("rst_rd_buf", rd_buf, 1);
        chk("rst_ovf", refresh_ovf, 0);

        // Requests pending but init_done low: nothing issues, backlog saturates
        RSTn = 1'b1;
        rd_fifo_level = '0;
        wr_fifo_level = 10'd512;
        repeat (1559) @(posedge CLK);
        @(negedge CLK);
        chk("ovf_before_4th_wrap", refresh_ovf, 0);
        chk("pend_saturated", dut.ref_pend_q, 3);
        @(negedge CLK);
        chk("ovf_at_4th_wrap", refresh_ovf, 1);
        repeat (440) @(negedge CLK);
        chk("no_cmd_before_init", cmd_valid, 0);
        chk("ovf_sticky", refresh_ovf, 1);

        // Reset again, wait one refresh wrap, then check priority ordering
        RSTn = 1'b0;
        rd_fifo_level = 10'd1023;
        wr_fifo_level = '0;
        repeat (2) @(negedge CLK);
        chk("ovf_cleared", refresh_ovf, 0);
        RSTn = 1'b1;
        repeat (400) @(negedge CLK);
        chk("pend_one", dut.ref_pend_q, 1);
        push(2'b10, 24'h000000, 9'd0);
        push(2'b01, 24'h800000, 9'd256);
        for (int k = 1; k <= 1205; k++) push(2'b00, 24'((k - 1) % 1200 * 256), 9'd256);
        push(2'b00, 24'h800000, 9'd256);
        init_done = 1'b1;
        rd_fifo_level = '0;
        wr_fifo_level = 10'd512;

        guard = 0;
        while (rd_hs < 1 && guard < 200) begin at_pos(1); guard++; end
        chk("first_read_accepted", rd_hs, 1);
        rd_fifo_level = 10'd1023;

        // Full-frame write sweep then wrap, up to the write at pointer 1024
        guard = 0;
        while (wr_hs < 1205 && guard < 30000) begin at_pos(1); guard++; end
        chk("sweep_writes", wr_hs, 1205);
        chk("wr_buf_sweep", wr_buf, 0);
        chk("rd_buf_sweep", rd_buf, 1);

        // Camera vsync while that write is busy: applied at its completion
        cmos_vsyn_pulse = 1'b1;
        at_pos(1);
        cmos_vsyn_pulse = 1'b0;
        chk("wr_buf_deferred", wr_buf, 0);
        guard = 0;
        while (wr_buf !== 1'b1 && guard < 40) begin at_pos(1); guard++; end
        chk("wr_buf_toggled", wr_buf, 1);
        chk("wr_ptr_reset", dut.wr_ptr_q, 0);
        guard = 0;
        while (wr_hs < 1206 && guard < 100) begin at_pos(1); guard++; end
        chk("write_new_buf_accepted", wr_hs, 1206);
        wr_fifo_level = '0;

        // Display vsync hands the completed camera buffer to scan-out
        at_pos(30);
        vga_vsyn_pulse = 1'b1;
        at_pos(1);
        vga_vsyn_pulse = 1'b0;
        chk("rd_buf_handoff", rd_buf, 0);
        push(2'b01, 24'h000000, 9'd256);
        rd_fifo_level = '0;
        guard = 0;
        while (rd_hs < 2 && guard < 100) begin at_pos(1); guard++; end
        chk("handoff_read_accepted", rd_hs, 2);
        rd_fifo_level = 10'd1023;

        // Stall cmd_ready across a refresh wrap
        guard = 0;
        while ((cyc % 390) != 360 && guard < 500) begin at_pos(1); guard++; end
        chk("stall_window_found", cyc % 390, 360);
        stall = 1'b1;
        push(2'b01, 24'h000100, 9'd256);
        rd_fifo_level = '0;
        guard = 0;
        while (cmd_valid !== 1'b1 && guard < 10) begin at_pos(1); guard++; end
        chk("stall_valid_up", cmd_valid, 1);
        errs = 0;
        repeat (50) begin
            at_pos(1);
            if (cmd_valid !== 1'b1 || cmd_type !== 2'b01 || cmd_addr !== 24'h000100 || cmd_len !== 9'd256)
                errs++;
        end
        chk("stall_stable", errs, 0);
        chk("ref_during_stall", dut.ref_pend_q, 1);
        chk("no_accept_in_stall", rd_hs, 2);
        stall = 1'b0;
        guard = 0;
        while (rd_hs < 3 && guard < 20) begin at_pos(1); guard++; end
        chk("stalled_read_accepted", rd_hs, 3);
        rd_fifo_level = 10'd1023;
        at_pos(60);
        chk("queue_drained", exp_q.size(), 0);
        chk("pend_drained", dut.ref_pend_q, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
